// File: rtl/bsram_boot_loader_pkg.sv
// Shared types and constants for the BSRAM boot loader: FSM states, frame magic
// and header byte positions.
package boot_loader_pkg;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

  // Byte positions within a frame header.
  localparam int HDR_MAGIC = 0;
  localparam int HDR_ALO   = 1;
  localparam int HDR_AHI   = 2;
  localparam int HDR_LLO   = 3;
  localparam int HDR_LHI   = 4;
  localparam int HDR_BYTES = 5;

  typedef enum logic [3:0] {
    S_SYNC,
    S_ALO,
    S_AHI,
    S_LLO,
    S_LHI,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } boot_state_e;

endpackage

// File: rtl/bsram_boot_loader_if.sv
// Byte stream valid/ready handshake feeding the boot loader.
interface bsram_boot_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bsram_boot_loader.sv
// Framed byte-stream loader driving the Gowin SDPB port-A write side; holds
// boot_mode until a frame with a matching XOR checksum has been committed.
module bsram_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 13,  // header address is 16 bits; 8 <= ADDR_W <= 16
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bsram_boot_loader_if.slave  stream,
  output logic                cea,
  output logic [ADDR_W-1:0]   ada,
  output logic [DATA_W-1:0]   din,
  output logic                boot_mode,
  output logic                done,
  output logic                error
);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       len_q;
  logic [7:0]        xor_q;
  logic              ready_st;
  logic              accept;
  logic              is_magic;
  logic              chk_ok;

  // Gating with rst_n keeps ready low while reset is held, yet lets it rise
  // combinationally in the first cycle after release.
  assign ready_st     = !(state_q inside {S_WRITE, S_DONE});
  assign stream.ready = rst_n && ready_st;
  assign accept       = stream.valid && stream.ready;
  assign is_magic     = (stream.data == BOOT_MAGIC);
  assign chk_ok       = (stream.data == xor_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_SYNC;
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC, S_ERR: if (accept && is_magic) state_d = S_ALO;
      S_ALO:         if (accept) state_d = S_AHI;
      S_AHI:         if (accept) state_d = S_LLO;
      S_LLO:         if (accept) state_d = S_LHI;
      S_LHI:         if (accept) state_d = ({stream.data, len_q[7:0]} == 16'd0) ? S_CHK : S_DATA;
      S_DATA:        if (accept) state_d = S_WRITE;
      S_WRITE:       state_d = (len_q == 16'd1) ? S_CHK : S_DATA;
      S_CHK:         if (accept) state_d = chk_ok ? S_DONE : S_ERR;
      S_DONE:        state_d = S_DONE;
      default:       state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      xor_q     <= '0;
      cea       <= 1'b0;
      ada       <= '0;
      din       <= '0;
      boot_mode <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // cea is a single-cycle strobe that covers exactly the S_WRITE cycle.
      cea <= 1'b0;
      case (state_q)
        S_SYNC, S_ERR: if (accept && is_magic) begin
          xor_q <= '0;
          error <= 1'b0;
        end
        S_ALO: if (accept) addr_q <= ADDR_W'(stream.data);
        S_AHI: if (accept) addr_q <= ADDR_W'({stream.data, addr_q[7:0]});
        S_LLO: if (accept) len_q[7:0]  <= stream.data;
        S_LHI: if (accept) len_q[15:8] <= stream.data;
        S_DATA: if (accept) begin
          din   <= stream.data;
          ada   <= addr_q;
          xor_q <= xor_q ^ stream.data;
          cea   <= 1'b1;
        end
        S_WRITE: begin
          addr_q <= addr_q + ADDR_W'(1);
          len_q  <= len_q - 16'd1;
        end
        S_CHK: if (accept) begin
          if (chk_ok) begin
            done      <= 1'b1;
            boot_mode <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsram_boot_loader.sv
// Directed bench for bsram_boot_loader with a behavioural BSRAM downstream and a
// port-A write monitor.
module tb_bsram_boot_loader;
  import boot_loader_pkg::*;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cea;
  logic [ADDR_W-1:0] ada;
  logic [7:0]        din;
  logic              boot_mode, done, error;

  bsram_boot_loader_if stream ();

  bsram_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stream    (stream),
    .cea       (cea),
    .ada       (ada),
    .din       (din),
    .boot_mode (boot_mode),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Behavioural SDPB: contents are unaffected by reset.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (cea) mem[ada] <= din;

  int n_checks = 0;
  int n_errors = 0;
  int tmo_cnt  = 0;
  int b2b_cnt  = 0;
  int rdy_wr   = 0;
  logic              prev_cea = 1'b0;
  logic [ADDR_W-1:0] log_addr[$];
  logic [7:0]        log_data[$];

  always @(negedge clk) begin
    if (cea) begin
      log_addr.push_back(ada);
      log_data.push_back(din);
      if (prev_cea) b2b_cnt++;
      if (stream.ready) rdy_wr++;
    end
    prev_cea = cea;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stream.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    stream.valid = 1'b0;
    repeat (gap) @(negedge clk);
    stream.valid = 1'b1;
    stream.data  = b;
    while (!stream.ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!stream.ready) tmo_cnt++;
    else @(negedge clk);
    stream.valid = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] f[$], input int from, input int to, input int max_gap);
    for (int i = from; i <= to; i++) send_byte(f[i], $urandom_range(0, max_gap));
  endtask

  task automatic check_writes(input string tag, input logic [ADDR_W-1:0] base,
                              input logic [7:0] exp_data[$]);
    check({tag, "_nwr"}, log_addr.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < log_addr.size(); i++) begin
      check($sformatf("%s_ada%0d", tag, i), log_addr[i], base + ADDR_W'(i));
      check($sformatf("%s_din%0d", tag, i), log_data[i], exp_data[i]);
      check($sformatf("%s_rd%0d", tag, i), mem[base + ADDR_W'(i)], exp_data[i]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] f[$];
    logic [7:0] pay[$];
    logic [7:0] x;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    stream.valid = 1'b0;
    stream.data  = 8'h00;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_ready", stream.ready, 1'b0);
    check("rst_cea",   cea,          1'b0);
    check("rst_ada",   ada,          '0);
    check("rst_din",   din,          8'h00);
    check("rst_boot",  boot_mode,    1'b1);
    check("rst_done",  done,         1'b0);
    check("rst_error", error,        1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", stream.ready, 1'b1);

    // Basic frame.
    good = '{8'hA5, 8'h00, 8'h02, 8'h04, 8'h00, 8'h06, 8'h07, 8'h08, 8'h09, 8'h00};
    @(negedge clk);
    send_range(good, 0, good.size() - 1, 0);
    repeat (3) @(negedge clk);
    check_writes("t1", 13'h0200, '{8'h06, 8'h07, 8'h08, 8'h09});
    check("t1_done",  done,      1'b1);
    check("t1_boot",  boot_mode, 1'b0);
    check("t1_error", error,     1'b0);
    check("t1_ready", stream.ready, 1'b0);

    // Bad checksum, then recovery with a good frame.
    do_reset();
    bad = '{8'hA5, 8'h00, 8'h02, 8'h04, 8'h00, 8'h06, 8'h07, 8'h08, 8'h09, 8'h01};
    send_range(bad, 0, bad.size() - 1, 0);
    repeat (2) @(negedge clk);
    check("t2_error", error,     1'b1);
    check("t2_done",  done,      1'b0);
    check("t2_boot",  boot_mode, 1'b1);
    check("t2_ready", stream.ready, 1'b1);
    send_byte(BOOT_MAGIC, 0);
    check("t2_errclr", error, 1'b0);
    send_range(good, 1, good.size() - 1, 0);
    repeat (2) @(negedge clk);
    check("t2_done2",  done,      1'b1);
    check("t2_boot2",  boot_mode, 1'b0);
    check("t2_error2", error,     1'b0);

    // Garbage before a zero-length frame.
    do_reset();
    f = '{8'h12, 8'h34, 8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    send_range(f, 0, f.size() - 1, 0);
    repeat (2) @(negedge clk);
    check("t3_nwr",  log_addr.size(), 0);
    check("t3_done", done,      1'b1);
    check("t3_boot", boot_mode, 1'b0);

    // Address wrap; upper address bits ignored.
    do_reset();
    f = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h11};
    send_range(f, 0, f.size() - 1, 0);
    repeat (2) @(negedge clk);
    check("t4_nwr",  log_addr.size(), 2);
    check("t4_a0",   log_addr[0], 13'h1FFF);
    check("t4_d0",   log_data[0], 8'hAA);
    check("t4_a1",   log_addr[1], 13'h0000);
    check("t4_d1",   log_data[1], 8'hBB);
    check("t4_rd0",  mem[13'h1FFF], 8'hAA);
    check("t4_rd1",  mem[13'h0000], 8'hBB);
    check("t4_done", done, 1'b1);

    // 16-byte payload with random valid gaps.
    do_reset();
    f = {};
    repeat (HDR_BYTES) f.push_back(8'h00);
    f[HDR_MAGIC] = BOOT_MAGIC;
    f[HDR_ALO]   = 8'h00;
    f[HDR_AHI]   = 8'h01;
    f[HDR_LLO]   = 8'd16;
    f[HDR_LHI]   = 8'h00;
    pay = {};
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      pay.push_back(8'h5A ^ 8'(i * 13));
      x = x ^ pay[i];
      f.push_back(pay[i]);
    end
    f.push_back(x);
    send_range(f, 0, f.size() - 1, 3);
    repeat (3) @(negedge clk);
    check_writes("t5", 13'h0100, pay);
    check("t5_done", done, 1'b1);
    check("t5_b2b",  b2b_cnt, 0);
    check("t5_rdywr", rdy_wr, 0);

    // Reset during the third payload byte's write, then resend.
    do_reset();
    for (int i = 0; i < 4; i++) mem[13'h0200 + i] = 8'h00;
    send_range(good, 0, HDR_BYTES + 1, 0);
    stream.valid = 1'b1;
    stream.data  = 8'h08;
    while (!stream.ready) @(negedge clk);
    @(posedge clk);
    #1;
    check("t6_cea_fly", cea, 1'b1);
    check("t6_ada_fly", ada, 13'h0202);
    #1;
    rst_n = 1'b0;
    stream.valid = 1'b0;
    #1;
    check("t6_rst_cea",   cea,          1'b0);
    check("t6_rst_ada",   ada,          '0);
    check("t6_rst_din",   din,          8'h00);
    check("t6_rst_ready", stream.ready, 1'b0);
    check("t6_rst_boot",  boot_mode,    1'b1);
    @(negedge clk);
    check("t6_part1", mem[13'h0201], 8'h07);
    check("t6_part2", mem[13'h0202], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
    send_range(good, 0, good.size() - 1, 1);
    repeat (3) @(negedge clk);
    check_writes("t6", 13'h0200, '{8'h06, 8'h07, 8'h08, 8'h09});
    check("t6_done", done,      1'b1);
    check("t6_boot", boot_mode, 1'b0);

    check("b2b_total", b2b_cnt, 0);
    check("rdy_write", rdy_wr,  0);
    check("timeouts",  tmo_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
